// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle registered integer execute unit.
// It accepts a decoded micro-op and registers the result, the RFLAGS image
// and any branch redirect. Outputs hold their values while the memory stage
// is blocked.
//
// Ports:
//   clk, reset_n      core clock, asynchronous active-low reset
//   enable            micro-op valid from the data-fetch stage
//   opcode[9:0]       {map[1:0], byte[7:0]}
//   oprd1/2/3[63:0]   operand values (oprd3 = immediate/displacement)
//   next_rip[63:0]    address of the following instruction
//   result[127:0]     execution result
//   rflags[63:0]      current flags image (CF=0, PF=2, ZF=6, SF=7, OF=11, bit1=1)
//   valid_out         result valid to the memory stage
//   mem_blocked       memory stage stall
//   branch            one-cycle fetch redirect pulse
//   branch_rip[63:0]  redirect target
//
// Optional feature: define ALU_MUL_EN to implement IMUL (opcode 1AF).
// Without it, opcode 1AF decodes as a NOP and no multiplier is built.
module alu_exec_unit (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic [9:0]   opcode,
  input  logic [63:0]  oprd1,
  input  logic [63:0]  oprd2,
  input  logic [63:0]  oprd3,
  input  logic [63:0]  next_rip,
  output logic [127:0] result,
  output logic [63:0]  rflags,
  output logic         valid_out,
  input  logic         mem_blocked,
  output logic         branch,
  output logic [63:0]  branch_rip
);

  localparam logic [63:0] FLAGS_RESET = 64'h2;

  // Builds a flags image from a 64-bit result. Only CF/PF/ZF/SF/OF are kept.
  function automatic logic [63:0] mk_flags(input logic [63:0] res,
                                           input logic        cf,
                                           input logic        of);
    logic [63:0] f;
    f     = FLAGS_RESET;
    f[0]  = cf;
    f[2]  = ~^res[7:0];
    f[6]  = (res == 64'd0);
    f[7]  = res[63];
    f[11] = of;
    return f;
  endfunction

  logic [64:0]  add_w;
  logic [64:0]  adc_w;
  logic [64:0]  sub_w;
  logic [63:0]  and_w;
  logic [63:0]  rel_tgt;
  logic         add_of;
  logic         adc_of;
  logic         sub_of;
  logic         jcc_true;
  logic         fl_cf, fl_pf, fl_zf, fl_sf, fl_of;

  logic [127:0] result_nxt;
  logic [63:0]  flags_nxt;
  logic         branch_nxt;

  assign add_w   = {1'b0, oprd1} + {1'b0, oprd2};
  assign adc_w   = {1'b0, oprd1} + {1'b0, oprd2} + {64'd0, rflags[0]};
  // Bit 64 of the 65-bit difference is the borrow out.
  assign sub_w   = {1'b0, oprd1} - {1'b0, oprd2};
  assign and_w   = oprd1 & oprd2;
  assign rel_tgt = next_rip + oprd3;

  assign add_of  = (oprd1[63] == oprd2[63]) && (add_w[63] != oprd1[63]);
  assign adc_of  = (oprd1[63] == oprd2[63]) && (adc_w[63] != oprd1[63]);
  assign sub_of  = (oprd1[63] != oprd2[63]) && (sub_w[63] != oprd1[63]);

  assign fl_cf = rflags[0];
  assign fl_pf = rflags[2];
  assign fl_zf = rflags[6];
  assign fl_sf = rflags[7];
  assign fl_of = rflags[11];

`ifdef ALU_MUL_EN
  logic [127:0] mul_w;
  logic         mul_ovf;
  // Sign-extend both operands to 128 bits; the low 128 bits of that product
  // are the exact signed 64x64 result.
  assign mul_w   = {{64{oprd1[63]}}, oprd1} * {{64{oprd2[63]}}, oprd2};
  assign mul_ovf = (mul_w[127:64] != {64{mul_w[63]}});
`endif

  // Jcc: opcode[3:1] selects the base condition and opcode[0] inverts it,
  // matching the x86 condition-code encoding.
  always_comb begin
    jcc_true = 1'b0;
    case (opcode[3:1])
      3'd0: jcc_true = fl_of;
      3'd1: jcc_true = fl_cf;
      3'd2: jcc_true = fl_zf;
      3'd3: jcc_true = fl_cf | fl_zf;
      3'd4: jcc_true = fl_sf;
      3'd5: jcc_true = fl_pf;
      3'd6: jcc_true = fl_sf ^ fl_of;
      3'd7: jcc_true = fl_zf | (fl_sf ^ fl_of);
      default: jcc_true = 1'b0;
    endcase
    jcc_true = jcc_true ^ opcode[0];
  end

  always_comb begin
    result_nxt = '0;
    flags_nxt  = rflags;
    branch_nxt = 1'b0;
    case (opcode)
      10'h001: begin
        result_nxt[63:0] = add_w[63:0];
        flags_nxt        = mk_flags(add_w[63:0], add_w[64], add_of);
      end
      10'h011: begin
        result_nxt[63:0] = adc_w[63:0];
        flags_nxt        = mk_flags(adc_w[63:0], adc_w[64], adc_of);
      end
      10'h029: begin
        result_nxt[63:0] = sub_w[63:0];
        flags_nxt        = mk_flags(sub_w[63:0], sub_w[64], sub_of);
      end
      10'h039: begin
        result_nxt[63:0] = oprd1;
        flags_nxt        = mk_flags(sub_w[63:0], sub_w[64], sub_of);
      end
      10'h009: begin
        result_nxt[63:0] = oprd1 | oprd2;
        flags_nxt        = mk_flags(oprd1 | oprd2, 1'b0, 1'b0);
      end
      10'h021: begin
        result_nxt[63:0] = and_w;
        flags_nxt        = mk_flags(and_w, 1'b0, 1'b0);
      end
      10'h031: begin
        result_nxt[63:0] = oprd1 ^ oprd2;
        flags_nxt        = mk_flags(oprd1 ^ oprd2, 1'b0, 1'b0);
      end
      10'h085: begin
        result_nxt[63:0] = oprd1;
        flags_nxt        = mk_flags(and_w, 1'b0, 1'b0);
      end
      10'h089: result_nxt[63:0] = oprd2;
      10'h08D: result_nxt[63:0] = oprd2 + oprd3;
      10'h050: begin
        result_nxt[63:0]   = oprd2;
        result_nxt[127:64] = oprd1 - 64'd8;
      end
      10'h058: result_nxt[127:64] = oprd2;
      10'h0C3: result_nxt[127:64] = oprd2;
      10'h0E8: begin
        result_nxt[63:0]   = next_rip;
        result_nxt[127:64] = oprd1 - 64'd8;
        branch_nxt         = 1'b1;
      end
      10'h310: result_nxt[63:0] = next_rip;
      10'h0E9: branch_nxt = 1'b1;
`ifdef ALU_MUL_EN
      10'h1AF: begin
        result_nxt = mul_w;
        flags_nxt  = mk_flags(mul_w[63:0], mul_ovf, mul_ovf);
      end
`endif
      default: begin
        if (opcode[9:4] == 6'h07) begin
          branch_nxt = jcc_true;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result     <= '0;
      rflags     <= FLAGS_RESET;
      valid_out  <= 1'b0;
      branch     <= 1'b0;
      branch_rip <= '0;
    end else if (!mem_blocked) begin
      if (enable) begin
        result    <= result_nxt;
        rflags    <= flags_nxt;
        valid_out <= 1'b1;
        branch    <= branch_nxt;
        if (branch_nxt) begin
          branch_rip <= rel_tgt;
        end
      end else begin
        result    <= '0;
        valid_out <= 1'b0;
        branch    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

  logic         clk;
  logic         reset_n;
  logic         enable;
  logic [9:0]   opcode;
  logic [63:0]  oprd1;
  logic [63:0]  oprd2;
  logic [63:0]  oprd3;
  logic [63:0]  next_rip;
  logic [127:0] result;
  logic [63:0]  rflags;
  logic         valid_out;
  logic         mem_blocked;
  logic         branch;
  logic [63:0]  branch_rip;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .opcode      (opcode),
    .oprd1       (oprd1),
    .oprd2       (oprd2),
    .oprd3       (oprd3),
    .next_rip    (next_rip),
    .result      (result),
    .rflags      (rflags),
    .valid_out   (valid_out),
    .mem_blocked (mem_blocked),
    .branch      (branch),
    .branch_rip  (branch_rip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one micro-op, lets it be accepted, and returns 1 time unit
  // after the edge with enable dropped.
  task automatic issue(input logic [9:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] nr);
    opcode   = op;
    oprd1    = a;
    oprd2    = b;
    oprd3    = c;
    next_rip = nr;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    enable   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    enable      = 1'b0;
    mem_blocked = 1'b0;
    opcode      = '0;
    oprd1       = '0;
    oprd2       = '0;
    oprd3       = '0;
    next_rip    = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (result !== 128'd0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", result);
    end
    n_tests++;
    if (rflags !== 64'h2) begin
      n_fail++; $display("FAIL reset_rflags: got %h expected 2", rflags);
    end
    n_tests++;
    if (valid_out !== 1'b0 || branch !== 1'b0 || branch_rip !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b b=%b rip=%h expected 0/0/0", valid_out, branch, branch_rip);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || rflags !== 64'h2) begin
      n_fail++; $display("FAIL post_reset: got v=%b fl=%h expected 0/2", valid_out, rflags);
    end
  endtask

  task automatic test_add();
    issue(10'h001, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'd0, 64'h8000_0000_0000_0000}) begin
      n_fail++; $display("FAIL add_result: got %h expected 8000000000000000", result);
    end
    n_tests++;
    if (rflags !== 64'h886) begin
      n_fail++; $display("FAIL add_flags: got %h expected 886", rflags);
    end
    n_tests++;
    if (valid_out !== 1'b1) begin
      n_fail++; $display("FAIL add_valid: got %b expected 1", valid_out);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || result !== 128'd0 || rflags !== 64'h886) begin
      n_fail++;
      $display("FAIL idle_after_add: got v=%b r=%h fl=%h expected 0/0/886", valid_out, result, rflags);
    end
  endtask

  task automatic test_sub_jcc();
    issue(10'h029, 64'd5, 64'd5, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h46) begin
      n_fail++; $display("FAIL sub_zero: got r=%h fl=%h expected 0/46", result, rflags);
    end
    issue(10'h074, 64'd0, 64'd0, 64'h20, 64'h1000);
    n_tests++;
    if (branch !== 1'b1 || branch_rip !== 64'h1020 || result !== 128'd0) begin
      n_fail++;
      $display("FAIL jcc_je: got b=%b rip=%h r=%h expected 1/1020/0", branch, branch_rip, result);
    end
    n_tests++;
    if (rflags !== 64'h46) begin
      n_fail++; $display("FAIL jcc_flags_hold: got %h expected 46", rflags);
    end
    issue(10'h075, 64'd0, 64'd0, 64'h20, 64'h1000);
    n_tests++;
    if (branch !== 1'b0 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL jcc_jne: got b=%b v=%b expected 0/1", branch, valid_out);
    end
  endtask

  task automatic test_adc();
    issue(10'h001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h47) begin
      n_fail++; $display("FAIL add_carry: got r=%h fl=%h expected 0/47", result, rflags);
    end
    issue(10'h011, 64'd1, 64'd2, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd4 || rflags !== 64'h2) begin
      n_fail++; $display("FAIL adc: got r=%h fl=%h expected 4/2", result, rflags);
    end
  endtask

  task automatic test_logic();
    issue(10'h031, 64'hFF, 64'h0F, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'hF0 || rflags !== 64'h6) begin
      n_fail++; $display("FAIL xor: got r=%h fl=%h expected f0/6", result, rflags);
    end
    issue(10'h021, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'd0, 64'h8000_0000_0000_0000} || rflags !== 64'h86) begin
      n_fail++; $display("FAIL and: got r=%h fl=%h expected 8000000000000000/86", result, rflags);
    end
    issue(10'h009, 64'h1, 64'h2, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'h3 || rflags !== 64'h6) begin
      n_fail++; $display("FAIL or: got r=%h fl=%h expected 3/6", result, rflags);
    end
    issue(10'h085, 64'h5, 64'hA, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'h5 || rflags !== 64'h46) begin
      n_fail++; $display("FAIL test: got r=%h fl=%h expected 5/46", result, rflags);
    end
  endtask

  task automatic test_cmp_jcc();
    issue(10'h039, 64'd3, 64'd5, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd3 || rflags !== 64'h83) begin
      n_fail++; $display("FAIL cmp: got r=%h fl=%h expected 3/83", result, rflags);
    end
    issue(10'h072, 64'd0, 64'd0, 64'h8, 64'h2000);
    n_tests++;
    if (branch !== 1'b1 || branch_rip !== 64'h2008) begin
      n_fail++; $display("FAIL jcc_jb: got b=%b rip=%h expected 1/2008", branch, branch_rip);
    end
    issue(10'h07C, 64'd0, 64'd0, 64'h10, 64'h2000);
    n_tests++;
    if (branch !== 1'b1 || branch_rip !== 64'h2010) begin
      n_fail++; $display("FAIL jcc_jl: got b=%b rip=%h expected 1/2010", branch, branch_rip);
    end
    issue(10'h07F, 64'd0, 64'd0, 64'h10, 64'h2000);
    n_tests++;
    if (branch !== 1'b0) begin
      n_fail++; $display("FAIL jcc_jg: got b=%b expected 0", branch);
    end
  endtask

  task automatic test_moves_stack();
    issue(10'h089, 64'd0, 64'h1234, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'h1234 || rflags !== 64'h83) begin
      n_fail++; $display("FAIL mov: got r=%h fl=%h expected 1234/83", result, rflags);
    end
    issue(10'h08D, 64'd0, 64'h1000, 64'h10, 64'd0);
    n_tests++;
    if (result !== 128'h1010) begin
      n_fail++; $display("FAIL lea: got %h expected 1010", result);
    end
    issue(10'h050, 64'h8000, 64'hAB, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'h7FF8, 64'hAB}) begin
      n_fail++; $display("FAIL push: got %h expected 7ff8_ab", result);
    end
    issue(10'h058, 64'h8000, 64'h55, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'h55, 64'd0}) begin
      n_fail++; $display("FAIL pop: got %h expected 55_0", result);
    end
    issue(10'h0C3, 64'd0, 64'h99, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'h99, 64'd0} || branch !== 1'b0) begin
      n_fail++; $display("FAIL ret: got r=%h b=%b expected 99_0/0", result, branch);
    end
  endtask

  task automatic test_control();
    issue(10'h0E8, 64'h7C00, 64'd0, 64'h100, 64'h40_0010);
    n_tests++;
    if (result !== {64'h7BF8, 64'h40_0010}) begin
      n_fail++; $display("FAIL call_rel_result: got %h expected 7bf8_400010", result);
    end
    n_tests++;
    if (branch !== 1'b1 || branch_rip !== 64'h40_0110) begin
      n_fail++; $display("FAIL call_rel_branch: got b=%b rip=%h expected 1/400110", branch, branch_rip);
    end
    issue(10'h310, 64'h7C00, 64'd0, 64'h100, 64'h2000);
    n_tests++;
    if (result !== 128'h2000 || branch !== 1'b0) begin
      n_fail++; $display("FAIL call_reg: got r=%h b=%b expected 2000/0", result, branch);
    end
    issue(10'h0E9, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h3000);
    n_tests++;
    if (branch !== 1'b1 || branch_rip !== 64'h2FF0 || result !== 128'd0) begin
      n_fail++; $display("FAIL jmp_back: got b=%b rip=%h r=%h expected 1/2ff0/0", branch, branch_rip, result);
    end
    issue(10'h105, 64'h1, 64'h2, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h83 || branch !== 1'b0) begin
      n_fail++; $display("FAIL syscall: got r=%h fl=%h b=%b expected 0/83/0", result, rflags, branch);
    end
    issue(10'h3FF, 64'h1, 64'h2, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h83 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL nop: got r=%h fl=%h v=%b expected 0/83/1", result, rflags, valid_out);
    end
  endtask

  task automatic test_stall();
    issue(10'h001, 64'd1, 64'd2, 64'd0, 64'd0);
    opcode      = 10'h001;
    oprd1       = 64'hFFFF_FFFF_FFFF_FFFF;
    oprd2       = 64'd1;
    enable      = 1'b1;
    mem_blocked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (result !== 128'd3 || valid_out !== 1'b1 || rflags !== 64'h6) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got r=%h v=%b fl=%h expected 3/1/6", i, result, valid_out, rflags);
      end
    end
    mem_blocked = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    n_tests++;
    if (result !== 128'd0 || valid_out !== 1'b1 || rflags !== 64'h47) begin
      n_fail++; $display("FAIL stall_release: got r=%h v=%b fl=%h expected 0/1/47", result, valid_out, rflags);
    end
  endtask

  task automatic test_imul();
`ifdef ALU_MUL_EN
    issue(10'h1AF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA ||
        rflags[0] !== 1'b0 || rflags[11] !== 1'b0 || rflags[7] !== 1'b1) begin
      n_fail++; $display("FAIL imul_neg: got r=%h fl=%h expected fff..fa CF=OF=0 SF=1", result, rflags);
    end
    issue(10'h1AF, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0);
    n_tests++;
    if (result !== {64'd1, 64'd0} || rflags[0] !== 1'b1 || rflags[11] !== 1'b1 || rflags[6] !== 1'b1) begin
      n_fail++; $display("FAIL imul_ovf: got r=%h fl=%h expected 1_0 CF=OF=ZF=1", result, rflags);
    end
`else
    issue(10'h1AF, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h47) begin
      n_fail++; $display("FAIL imul_nop: got r=%h fl=%h expected 0/47", result, rflags);
    end
`endif
  endtask

  task automatic test_async_reset();
    issue(10'h039, 64'd3, 64'd5, 64'd0, 64'd0);
    n_tests++;
    if (result !== 128'd3 || valid_out !== 1'b1) begin
      n_fail++; $display("FAIL cmp_before_reset: got r=%h v=%b expected 3/1", result, valid_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (result !== 128'd0 || rflags !== 64'h2 || valid_out !== 1'b0 || branch !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got r=%h fl=%h v=%b b=%b expected 0/2/0/0", result, rflags, valid_out, branch);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_jcc();
    test_adc();
    test_logic();
    test_cmp_jcc();
    test_moves_stack();
    test_control();
    test_stall();
    test_imul();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Single-cycle-registered integer execute unit of the pipelined x86-64 core, between data-fetch/schedule and the memory stage. Takes a decoded micro-op (10-bit opcode, up to three 64-bit operand values, next RIP) and produces a 128-bit result, an updated RFLAGS image, and branch redirects. It signals the memory stage that a result is valid, and it stalls when the memory stage is blocked.

## Interface
- Clock `clk`; reset `reset_n`, asynchronous, active-low.
- `clk`  in  1  core clock
- `reset_n`  in  1  async active-low reset
- `enable`  in  1  micro-op valid from data-fetch stage
- `opcode`  in  10  {map[1:0], byte[7:0]}; map 00 = one-byte, 01 = 0F-escape, 11 = group/extended
- `oprd1`, `oprd2`, `oprd3`  in  64 each  operand values (oprd3 = immediate/displacement)
- `next_rip`  in  64  address of following instruction
- `result`  out  128  execution result
- `rflags`  out  64  current flags image
- `valid_out`  out  1  result valid to memory stage
- `mem_blocked`  in  1  memory stage stall
- `branch`  out  1  redirect fetch
- `branch_rip`  out  64  redirect target

## Operation
- Let r = result. Opcodes (hex):
  - 001 ADD: r=o1+o2.
  - 011 ADC: r=o1+o2+CF.
  - 029 SUB: r=o1-o2.
  - 039 CMP: flags of o1-o2; r=o1.
  - 009 OR, 021 AND, 031 XOR: bitwise.
  - 085 TEST: flags of o1&o2; r=o1.
  - 089 MOV: r=o2.
  - 08D LEA: r=o2+o3.
- Result width: arithmetic/logic results occupy r[63:0]; r[127:64]=0 unless stated.
- Stack and control:
  - 050 PUSH: r[63:0]=o2, r[127:64]=o1-8.
  - 058 POP: r[127:64]=o2, r[63:0]=0.
  - 0C3 RET: r[127:64]=o2; no branch, since writeback redirects.
  - 0E8 CALL rel: r[63:0]=next_rip, r[127:64]=o1-8; branch to next_rip+o3.
  - 310 CALL reg: r[63:0]=next_rip; no branch.
  - 0E9 JMP rel: branch to next_rip+o3.
  - 070–07F Jcc: condition on low nibble, x86 encoding — O, NO, B(CF), AE, E(ZF), NE, BE(CF|ZF), A, S, NS, P, NP, L(SF≠OF), GE, LE(ZF|SF≠OF), G. Branch only when true; r=0.
  - 1AF IMUL: signed 64×64 into full 128-bit r. CF=OF=(r[127:64] ≠ {64{r[63]}}); ZF/SF from r[63:0].
  - 105 SYSCALL: r=0, flags unchanged.
  - Any other opcode: NOP, r=0, flags unchanged.
- Flag bits: CF=0, PF=2, ZF=6, SF=7, OF=11; bit1 always 1; all other bits 0.
  - ADD/ADC/SUB/CMP: full CF/OF/ZF/SF/PF on 64-bit result; SUB/CMP CF = borrow.
  - Logic ops: CF=OF=0, ZF/SF/PF from result.
  - PF = even parity of r[7:0].
  - MOV, LEA, stack ops and branches leave flags unchanged.
- Flags register is internal and updated only on accepted micro-ops. Jcc reads the register value before the current op.

## Timing
- Reset (async, while reset_n=0):
  - result=0, rflags=64'h2, valid_out=0, branch=0, branch_rip=0.
- Accept: rising edge with enable=1 and mem_blocked=0. Outputs update on that edge; latency 1 cycle.
- valid_out=1 for exactly the cycle after an accept.
- branch is a one-cycle pulse aligned with valid_out. It is 0 in every cycle without an accept.
- mem_blocked=1: all outputs including valid_out and branch hold their values; inputs are not consumed; flags not updated. The upstream stage holds its micro-op.
- enable=0 with mem_blocked=0: next edge drives valid_out=0, branch=0, result=0; rflags holds.
- reset_n asserted mid-operation: in-flight result discarded; flags return to 64'h2.

## Configuration
- `ALU_MUL_EN` defined: IMUL (1AF) implemented as above.
- `ALU_MUL_EN` undefined: 1AF decodes as NOP (r=0, flags unchanged); no multiplier inferred.

## Test plan
- After reset release: rflags=0x2, valid_out=0. ADD o1=0x7FFF_FFFF_FFFF_FFFF, o2=1 -> next cycle r[63:0]=0x8000_0000_0000_0000, OF=1, SF=1, CF=0, valid_out=1 for one cycle.
- SUB o1=5, o2=5 -> ZF=1, PF=1, CF=0. Following Jcc 074 with next_rip=0x1000, o3=0x20 -> branch=1, branch_rip=0x1020. Jcc 075 in the same state -> branch=0.
- CALL rel o1=0x7C00, next_rip=0x400010, o3=0x100 -> r[63:0]=0x400010, r[127:64]=0x7BF8, branch_rip=0x400110.
- mem_blocked=1 for 3 cycles while a new ADD is presented -> result, valid_out and rflags frozen. Op accepted on the first unblocked edge.
- IMUL o1=-2, o2=3 with `ALU_MUL_EN` -> r=128'hFFFF…FFFA, CF=OF=0. With o1=o2=2^32 -> r[127:64]=1, CF=OF=1.
- Assert reset_n=0 mid-cycle during a CMP -> outputs clear immediately, without waiting for a clock edge.
